// File: rtl/hd_pkg.sv
// hd_pkg: shared defaults and FSM encoding for the HD temporal encoder.
package hd_pkg;
    localparam int HV_DIMENSION_DEF = 1024;
    localparam int MAX_NGRAM_DEF    = 4;
    localparam int NGRAM_W_DEF      = $clog2(MAX_NGRAM_DEF + 1);
    typedef logic [0:HV_DIMENSION_DEF-1] hypervector_t;
    localparam logic [0:0] WARMUP = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;
endpackage

// File: rtl/ngram_history.sv
// ngram_history: rotating history of past hypervectors and their masked XOR binding.
// Ports: Clk_CI/Reset_RI clock and async reset; Shift_SI pushes Hv_DI into the history;
// Clear_SI zeroes the history; NGram_SI active n; Bound_DO = Hv_DI ^ H[1] ^ .. ^ H[n-1].
module ngram_history #(
    parameter int HV_DIMENSION = 1024,
    parameter int MAX_NGRAM    = 4,
    parameter int NGRAM_W      = $clog2(MAX_NGRAM + 1)
) (
    input  logic                    Clk_CI,
    input  logic                    Reset_RI,
    input  logic                    Shift_SI,
    input  logic                    Clear_SI,
    input  logic [NGRAM_W-1:0]      NGram_SI,
    input  logic [0:HV_DIMENSION-1] Hv_DI,
    output logic [0:HV_DIMENSION-1] Bound_DO
);
    logic [0:HV_DIMENSION-1] hist_q [1:MAX_NGRAM-1];

    // element i moves to i+1, the last element wraps to 0
    function automatic logic [0:HV_DIMENSION-1] rot(input logic [0:HV_DIMENSION-1] v);
        return {v[HV_DIMENSION-1], v[0:HV_DIMENSION-2]};
    endfunction

    always_ff @(posedge Clk_CI or posedge Reset_RI)
        if (Reset_RI)
            for (int k = 1; k < MAX_NGRAM; k++) hist_q[k] <= '0;
        else if (Clear_SI)
            for (int k = 1; k < MAX_NGRAM; k++) hist_q[k] <= '0;
        else if (Shift_SI) begin
            hist_q[1] <= rot(Hv_DI);
            for (int k = 2; k < MAX_NGRAM; k++) hist_q[k] <= rot(hist_q[k-1]);
        end

    // registers at index >= n do not take part in the binding
    always_comb begin
        Bound_DO = Hv_DI;
        for (int k = 1; k < MAX_NGRAM; k++)
            Bound_DO = (k < int'(NGram_SI)) ? Bound_DO ^ hist_q[k] : Bound_DO;
    end
endmodule

// File: rtl/temporal_ngram_encoder.sv
// temporal_ngram_encoder: n-gram temporal encoder with warm-up, clear and valid/ready output stage.
// Ports: Clk_CI/Reset_RI clock and async reset; ValidIn_SI/ReadyOut_SO/HypervectorIn_DI upstream;
// NGramSize_SI n-gram length (sampled after reset and on Clear_SI); Clear_SI flush;
// ValidOut_SO/ReadyIn_SI/HypervectorOut_DO downstream; WarmupDone_SO history full.
module temporal_ngram_encoder import hd_pkg::*; #(
    parameter int HV_DIMENSION = HV_DIMENSION_DEF,
    parameter int MAX_NGRAM    = MAX_NGRAM_DEF,
    parameter int NGRAM_W      = $clog2(MAX_NGRAM + 1)
) (
    input  logic                    Clk_CI,
    input  logic                    Reset_RI,
    input  logic                    ValidIn_SI,
    output logic                    ReadyOut_SO,
    input  logic [0:HV_DIMENSION-1] HypervectorIn_DI,
    input  logic [NGRAM_W-1:0]      NGramSize_SI,
    input  logic                    Clear_SI,
    output logic                    ValidOut_SO,
    input  logic                    ReadyIn_SI,
    output logic [0:HV_DIMENSION-1] HypervectorOut_DO,
    output logic                    WarmupDone_SO
);
    logic [NGRAM_W-1:0]      n_q, n_in, n_eff, cnt_q;
    logic [0:0]              state_q;
    logic                    sampled_q, sample, accept, fire, valid_q;
    logic [0:HV_DIMENSION-1] bound, hv_q;

    assign n_in = (NGramSize_SI <= NGRAM_W'(1)) ? NGRAM_W'(1) :
                  (NGramSize_SI > NGRAM_W'(MAX_NGRAM)) ? NGRAM_W'(MAX_NGRAM) : NGramSize_SI;
    // the freshly clamped value is used in the sampling cycle itself
    assign sample        = !sampled_q | Clear_SI;
    assign n_eff         = sample ? n_in : n_q;
    assign ReadyOut_SO   = (!valid_q | ReadyIn_SI) & !Clear_SI;
    assign accept        = ValidIn_SI & ReadyOut_SO;
    assign fire          = accept & ((state_q == STREAM) | (cnt_q == n_eff - NGRAM_W'(1)));
    assign ValidOut_SO   = valid_q;
    assign HypervectorOut_DO = hv_q;
    assign WarmupDone_SO = state_q == STREAM;

    ngram_history #(
        .HV_DIMENSION(HV_DIMENSION),
        .MAX_NGRAM   (MAX_NGRAM),
        .NGRAM_W     (NGRAM_W)
    ) u_history (
        .Clk_CI  (Clk_CI),
        .Reset_RI(Reset_RI),
        .Shift_SI(accept),
        .Clear_SI(Clear_SI),
        .NGram_SI(n_eff),
        .Hv_DI   (HypervectorIn_DI),
        .Bound_DO(bound)
    );

    always_ff @(posedge Clk_CI or posedge Reset_RI)
        if (Reset_RI) begin
            n_q       <= NGRAM_W'(MAX_NGRAM);
            sampled_q <= 1'b0;
            state_q   <= WARMUP;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            hv_q      <= '0;
        end else begin
            if (sample) n_q <= n_in;
            sampled_q <= 1'b1;
            if (Clear_SI) begin
                state_q <= WARMUP;
                cnt_q   <= '0;
                valid_q <= 1'b0;
                hv_q    <= '0;
            end else begin
                if (accept && cnt_q != NGRAM_W'(MAX_NGRAM - 1)) cnt_q <= cnt_q + NGRAM_W'(1);
                // n = 1 needs no history, so the stream starts without any accept
                if (state_q == WARMUP && (fire || n_eff == NGRAM_W'(1))) state_q <= STREAM;
                if (fire) begin
                    valid_q <= 1'b1;
                    hv_q    <= bound;
                end else if (ReadyIn_SI)
                    valid_q <= 1'b0;
            end
        end
endmodule

// File: tb/tb_temporal_ngram_encoder.sv
// tb_temporal_ngram_encoder: directed bench with a transaction-level model checked every cycle.
module tb_temporal_ngram_encoder;
    localparam int HV = 8;
    localparam int MX = 4;
    localparam int NW = 3;

    logic          clk = 0, rst = 1, vin = 0, clr = 0, rdy = 1;
    logic [NW-1:0] ngs = '0;
    logic [HV-1:0] din = '0, dout;
    logic          rdy_o, vout, wd;
    int            n_chk = 0, n_pass = 0;

    logic          m_v, m_wd, m_sampled;
    logic [7:0]    m_d;
    int            m_n, m_cnt;
    logic [7:0]    past[$];
    logic [7:0]    got[$];

    temporal_ngram_encoder #(.HV_DIMENSION(HV), .MAX_NGRAM(MX), .NGRAM_W(NW)) dut (
        .Clk_CI           (clk),
        .Reset_RI         (rst),
        .ValidIn_SI       (vin),
        .ReadyOut_SO      (rdy_o),
        .HypervectorIn_DI (din),
        .NGramSize_SI     (ngs),
        .Clear_SI         (clr),
        .ValidOut_SO      (vout),
        .ReadyIn_SI       (rdy),
        .HypervectorOut_DO(dout),
        .WarmupDone_SO    (wd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic int clampn(input logic [NW-1:0] v);
        return (v <= 1) ? 1 : ((v > MX) ? MX : int'(v));
    endfunction

    function automatic logic [7:0] rotr(input logic [7:0] v, input int k);
        logic [7:0] r = v;
        for (int i = 0; i < k; i++) r = {r[0], r[7:1]};
        return r;
    endfunction

    // result = x bound with the k-th previous input rotated k times, for k < n
    task automatic model_step();
        int nn;
        logic acc, prod;
        logic [7:0] d;
        d = '0;
        prod = 1'b0;
        if (rst) begin
            m_v = 0; m_d = 0; m_wd = 0; m_sampled = 0; m_n = MX; m_cnt = 0;
            past.delete();
            return;
        end
        nn = (!m_sampled || clr) ? clampn(ngs) : m_n;
        if (clr) begin
            m_v = 0; m_d = 0; m_wd = 0; m_cnt = 0;
            past.delete();
        end else begin
            acc = vin && (!m_v || rdy);
            if (acc) begin
                m_cnt++;
                prod = m_cnt >= nn;
                d = din;
                for (int k = 1; k < nn; k++)
                    if (k <= past.size()) d ^= rotr(past[k-1], k);
                past.push_front(din);
                if (past.size() > MX - 1) void'(past.pop_back());
            end
            if (prod) begin
                m_v = 1;
                m_d = d;
            end else if (rdy) m_v = 0;
            if (nn == 1 || prod) m_wd = 1;
        end
        if (!m_sampled || clr) begin
            m_n = nn;
            m_sampled = 1;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("valid_out", vout, m_v);
            chk("data_out", dout, m_d);
            chk("ready_out", rdy_o, (!m_v || rdy) && !clr);
            chk("warmup_done", wd, m_wd);
            if (vout && rdy && !clr) got.push_back(dout);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [NW-1:0] n);
        rst = 1; vin = 0; clr = 0; rdy = 1; ngs = n;
        tick();
        tick();
        rst = 0;
        got.delete();
    endtask

    task automatic send(input logic [7:0] x);
        bit r;
        int t;
        t = 0;
        vin = 1;
        din = x;
        do begin
            @(negedge clk);
            r = rdy_o;
            @(posedge clk);
            #1;
            t++;
        end while (!r && t < 50);
        if (!r) begin
            n_chk++;
            $display("FAIL send_timeout: input %0h not accepted within 50 cycles", x);
        end
        vin = 0;
    endtask

    task automatic chk_got(input string nm, input int cnt, input logic [7:0] a, input logic [7:0] b);
        chk({nm, "_count"}, got.size(), cnt);
        if (got.size() > 0) chk({nm, "_first"}, got[0], a);
        if (cnt > 1 && got.size() > 1) chk({nm, "_second"}, got[1], b);
    endtask

    initial begin
        // n=3 warm-up then streaming
        do_reset(3);
        send(8'h80);
        send(8'h80);
        chk("s1_warm_valid", vout, 0);
        chk("s1_warm_done", wd, 0);
        send(8'h80);
        send(8'h01);
        repeat (3) tick();
        chk_got("s1", 2, 8'hE0, 8'h61);

        // downstream stall holds the output and blocks input
        do_reset(3);
        send(8'h80);
        send(8'h80);
        send(8'h80);
        rdy = 0; vin = 1; din = 8'h01;
        repeat (3) begin
            @(negedge clk);
            chk("s2_hold_valid", vout, 1);
            chk("s2_hold_data", dout, 8'hE0);
            chk("s2_hold_ready", rdy_o, 0);
            @(posedge clk);
            #1;
        end
        rdy = 1;
        send(8'h01);
        repeat (3) tick();
        chk_got("s2", 2, 8'hE0, 8'h61);

        // n=1 and n=0 pass inputs straight through
        for (int i = 0; i < 2; i++) begin
            do_reset(i == 0 ? 3'd1 : 3'd0);
            tick();
            chk("s3_warm_done", wd, 1);
            send(8'h5A);
            send(8'h3C);
            repeat (3) tick();
            chk_got("s3", 2, 8'h5A, 8'h3C);
        end

        // clear in STREAM with a pending output and a valid input
        do_reset(3);
        send(8'h80);
        send(8'h80);
        send(8'h80);
        clr = 1; vin = 1; din = 8'h01;
        @(negedge clk);
        chk("s4_clear_ready", rdy_o, 0);
        @(posedge clk);
        #1;
        clr = 0; vin = 0;
        chk("s4_cleared_valid", vout, 0);
        chk("s4_cleared_done", wd, 0);
        got.delete();
        send(8'h10);
        send(8'h20);
        chk("s4_rewarm_valid", vout, 0);
        send(8'h40);
        repeat (3) tick();
        chk_got("s4", 1, 8'h54, 8'h00);

        // oversized n clamps to MAX_NGRAM
        do_reset(7);
        send(8'h80);
        send(8'h00);
        send(8'h00);
        chk("s5_warm_valid", vout, 0);
        chk("s5_warm_done", wd, 0);
        send(8'h00);
        repeat (3) tick();
        chk_got("s5", 1, 8'h10, 8'h00);

        // asynchronous reset with an output pending
        do_reset(3);
        send(8'h80);
        send(8'h80);
        send(8'h80);
        rdy = 0;
        #2;
        rst = 1;
        #1;
        chk("s6_reset_valid", vout, 0);
        chk("s6_reset_data", dout, 8'h00);
        chk("s6_reset_done", wd, 0);
        ngs = 2;
        tick();
        rst = 0; rdy = 1;
        got.delete();
        send(8'h33);
        send(8'h00);
        repeat (3) tick();
        chk_got("s6", 1, 8'h99, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/temporal_ngram_encoder.md
Name: temporal_ngram_encoder

Overview:
Parametrised temporal (n-gram) encoder for the HD sensor-fusion pipeline. It sits between the spatial encoder and the associative memory. It keeps a rotating history of the last N-1 input hypervectors and emits the XOR binding of the current input with the rotated history. Compared with the fixed-size encoder, it adds:
- a run-time selectable n-gram length (1..MAX_NGRAM)
- warm-up suppression, so no output is produced until N inputs have been absorbed
- a synchronous history clear
- a fully pipelined valid/ready handshake with throughput of 1 input per cycle

Parameters:
HV_DIMENSION, 1024, hypervector width in bits; index 0 is the MSB, vector declared [0:HV_DIMENSION-1].
MAX_NGRAM, 4, maximum n-gram length; number of history registers = MAX_NGRAM-1; must be >= 2.
NGRAM_W, $clog2(MAX_NGRAM+1), width of the run-time n-gram size input.

Ports:
Clk_CI  in  1  clock
Reset_RI  in  1  asynchronous, active-high reset
ValidIn_SI  in  1  upstream hypervector valid
ReadyOut_SO  out  1  block can accept an input this cycle
HypervectorIn_DI  in  HV_DIMENSION  input hypervector
NGramSize_SI  in  NGRAM_W  requested n-gram length; sampled only at reset release and on Clear_SI
Clear_SI  in  1  synchronous flush of history, counter and output register
ValidOut_SO  out  1  output hypervector valid
ReadyIn_SI  in  1  downstream ready
HypervectorOut_DO  out  HV_DIMENSION  bound n-gram hypervector (registered)
WarmupDone_SO  out  1  history is full for the active n-gram length

Behaviour:
- Clocking and reset: single clock. Reset_RI is asynchronous and active-high.
- Reset values: history = 0, fill counter = 0, state = WARMUP, ValidOut_SO = 0, HypervectorOut_DO = 0, WarmupDone_SO = 0, active n = MAX_NGRAM. On the first cycle after reset, NGramSize_SI is latched.
- Active n: n = NGramSize_SI, clamped. A value of 0 or 1 gives n = 1; a value greater than MAX_NGRAM gives n = MAX_NGRAM. Changes on NGramSize_SI are ignored except at the sampling points above.
- Rotation rot(v): element i moves to i+1 and element HV_DIMENSION-1 wraps to 0. In hex with index 0 as MSB, this is a 1-bit right rotate.
- Accept condition: accept = ValidIn_SI & ReadyOut_SO & !Clear_SI.
- On accept:
  - H[1] <= rot(x); H[k] <= rot(H[k-1]) for k = 2..MAX_NGRAM-1.
  - result = x ^ H[1] ^ ... ^ H[n-1], using pre-update history; registers with index >= n are excluded.
- FSM, state WARMUP:
  - Each accept increments the fill counter and produces no output.
  - When the fill counter equals n-1 at an accept, that accept produces an output and the FSM moves to STREAM.
  - If n = 1, the FSM enters STREAM on the cycle after the sampling point.
- FSM, state STREAM: every accept produces an output. The fill counter saturates.
- WarmupDone_SO: equals (state == STREAM).
- Output register: single-entry pipeline stage with latency 1 cycle from accept to ValidOut_SO.
  - ReadyOut_SO = !ValidOut_SO | ReadyIn_SI, gated low during Clear_SI.
  - ValidOut_SO clears on ReadyIn_SI when no new result is loaded.
  - While ValidOut_SO = 1 and ReadyIn_SI = 0, HypervectorOut_DO is held stable and no input is accepted.
  - Simultaneous pop and push in the same cycle loads the new result, keeps ValidOut_SO = 1, and sustains full throughput.
- Warm-up accepts: an accept that produces no output does not touch the output register. A pending output still drains normally.
- Clear_SI priority: Clear_SI has priority over accept. In the cycle it is asserted:
  - history and counter are zeroed, state = WARMUP, ValidOut_SO = 0 (pending output discarded);
  - n is re-sampled;
  - the input is not consumed.
- Reset mid-transfer: asynchronous reset discards all state immediately. Outputs drop to their reset values within the same cycle.
- ValidIn_SI = 0: no state change except draining the output register.

Decomposition:
- Shared package hd_pkg: HV_DIMENSION, MAX_NGRAM, NGRAM_W defaults, a hypervector typedef, and the FSM state encoding (WARMUP, STREAM).
- One sub-module, ngram_history: holds the MAX_NGRAM-1 rotating registers with shift-enable and clear, and outputs the masked XOR of the first n-1 entries.
- The top level holds the FSM, fill counter, clamp logic and output register.

Test Plan:
(All scenarios use HV_DIMENSION=8, MAX_NGRAM=4.)
1. n=3, inputs 80, 80, 80, 01 back-to-back with ReadyIn_SI=1 -> no ValidOut_SO for the first two inputs; outputs E0 then 61; WarmupDone_SO rises with the E0 output.
2. Scenario 1 with ReadyIn_SI low for 3 cycles after the E0 output -> E0 held stable, ReadyOut_SO=0, input 01 not consumed; 61 appears after the stall ends.
3. n=1 (and n=0), inputs 5A, 3C -> outputs 5A, 3C with 1-cycle latency; WarmupDone_SO=1 from the first cycle after sampling.
4. In STREAM, assert Clear_SI with ValidIn_SI=1 and ValidOut_SO=1 -> input not consumed, ValidOut_SO=0; the next n-1 accepts produce no output and the FSM re-warms.
5. NGramSize_SI=7 at reset release -> clamped to n=4; first output on the 4th accept; inputs 80, 00, 00, 00 give output 10.
6. Assert Reset_RI asynchronously mid-stream with a pending output -> ValidOut_SO, HypervectorOut_DO and WarmupDone_SO go to 0 before the next clock edge; history is zero afterwards.
